// File: rtl/vtg_pkg.sv
// vtg_pkg: default 384x264 raster timing constants and the range helper shared by the timing generator.
package vtg_pkg;
    localparam int DEF_HW        = 9;
    localparam int DEF_VW        = 9;
    localparam int DEF_H_START   = 128;
    localparam int DEF_H_END     = 511;
    localparam int DEF_H_VINC    = 175;
    localparam int DEF_VCLK_LEN  = 32;
    localparam int DEF_V_START   = 248;
    localparam int DEF_V_END     = 511;
    localparam int DEF_VBL_START = 496;
    localparam int DEF_VBL_END   = 272;
    localparam int DEF_VBLH_END  = 272;
    localparam int DEF_DMA_START = 480;

    function automatic logic in_range(input int unsigned v, input int unsigned lo, input int unsigned hi);
        return v >= lo && v < hi;
    endfunction
endpackage

// File: rtl/vtg_wrap_counter.sv
// vtg_wrap_counter: enabled up-counter that reloads START after END, flagging the wrap value.
module vtg_wrap_counter #(
    parameter int W     = 9,
    parameter int START = 0,
    parameter int END   = 511
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         wrap
);
    assign wrap = q == W'(END);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= W'(START);
        else if (en) q <= wrap ? W'(START) : q + W'(1);
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator (counters, blanking, syncs, DMA window, parity).
// Define VTG_IRQ_EN to build the vblank and raster-line compare interrupts; otherwise both IRQs are tied 0.
module video_timing_gen import vtg_pkg::*; #(
    parameter int HW        = DEF_HW,
    parameter int VW        = DEF_VW,
    parameter int H_START   = DEF_H_START,
    parameter int H_END     = DEF_H_END,
    parameter int H_VINC    = DEF_H_VINC,
    parameter int VCLK_LEN  = DEF_VCLK_LEN,
    parameter int V_START   = DEF_V_START,
    parameter int V_END     = DEF_V_END,
    parameter int VBL_START = DEF_VBL_START,
    parameter int VBL_END   = DEF_VBL_END,
    parameter int VBLH_END  = DEF_VBLH_END,
    parameter int DMA_START = DEF_DMA_START
) (
    input  logic          i_EMU_MCLK,
    input  logic          i_MRST_n,
    input  logic          i_EMU_CLK6MPCEN_n,
    input  logic          i_HFLIP,
    input  logic          i_VFLIP,
    input  logic [VW-1:0] i_LINE_CMP,
    output logic [HW-1:0] o_ABS_H,
    output logic [VW-2:0] o_ABS_V,
    output logic [HW-2:0] o_FLIP_H,
    output logic [VW-2:0] o_FLIP_V,
    output logic          o_HBLANK_n,
    output logic          o_VBLANK_n,
    output logic          o_VBLANKH_n,
    output logic          o_DMA_n,
    output logic          o_VCLK,
    output logic          o_FRAMEPARITY,
    output logic          o_VSYNC_n,
    output logic          o_CSYNC_n,
    output logic          o_VBL_IRQ,
    output logic          o_LINE_IRQ
);
    logic          tick, h_wrap, v_wrap, v_adv;
    logic [HW-1:0] h;
    logic [VW-1:0] v, v_next;

    assign tick   = ~i_EMU_CLK6MPCEN_n;
    assign v_adv  = tick && h == HW'(H_VINC);
    assign v_next = v + VW'(1);

    vtg_wrap_counter #(.W(HW), .START(H_START), .END(H_END)) u_h (
        .clk(i_EMU_MCLK), .rst_n(i_MRST_n), .en(tick), .q(h), .wrap(h_wrap)
    );

    vtg_wrap_counter #(.W(VW), .START(V_START), .END(V_END)) u_v (
        .clk(i_EMU_MCLK), .rst_n(i_MRST_n), .en(v_adv), .q(v), .wrap(v_wrap)
    );

    // V-derived flags hold across the V_END->V_START reload; VCLK holds on the H reload tick.
    always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n)
        if (!i_MRST_n) begin
            o_VBLANK_n    <= 1'b0;
            o_VBLANKH_n   <= 1'b0;
            o_DMA_n       <= 1'b1;
            o_VCLK        <= 1'b0;
            o_FRAMEPARITY <= 1'b0;
        end else begin
            if (tick && !h_wrap) o_VCLK <= in_range(32'(h), H_VINC, H_VINC + VCLK_LEN);
            if (v_adv && !v_wrap) begin
                o_VBLANK_n    <= in_range(32'(v_next), VBL_END, VBL_START);
                o_VBLANKH_n   <= !in_range(32'(v_next), V_START, VBLH_END);
                o_DMA_n       <= !in_range(32'(v_next), DMA_START, VBL_START);
                o_FRAMEPARITY <= o_FRAMEPARITY ^ (v_next == VW'(VBL_START));
            end
        end

`ifdef VTG_IRQ_EN
    always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n)
        if (!i_MRST_n) begin
            o_VBL_IRQ  <= 1'b0;
            o_LINE_IRQ <= 1'b0;
        end else begin
            o_VBL_IRQ  <= v_adv && !v_wrap && v_next == VW'(VBL_START);
            o_LINE_IRQ <= v_adv && !v_wrap && v_next == i_LINE_CMP;
        end
`else
    logic unused_cmp;
    assign unused_cmp = ^i_LINE_CMP;
    assign o_VBL_IRQ  = 1'b0;
    assign o_LINE_IRQ = 1'b0;
`endif

    assign o_ABS_H    = h;
    assign o_ABS_V    = v[VW-2:0];
    assign o_FLIP_H   = h[HW-2:0] ^ {(HW-1){i_HFLIP}};
    assign o_FLIP_V   = v[VW-2:0] ^ {(VW-1){i_VFLIP}};
    assign o_HBLANK_n = h[HW-1];
    assign o_VSYNC_n  = v[VW-1];
    assign o_CSYNC_n  = v[VW-1] & ~o_VCLK;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of a default-timing instance and a short-frame instance.
module tb_video_timing_gen;
`ifdef VTG_IRQ_EN
    localparam int IRQ = 1;
`else
    localparam int IRQ = 0;
`endif
    logic       clk = 1'b0;
    logic       rst_n, ten_n, hflip, vflip;
    logic [8:0] cmp_a, cmp_b, a_h, b_h;
    logic [7:0] a_v, b_v, a_fh, b_fh, a_fv, b_fv;
    logic a_hb, a_vb, a_vbh, a_dma, a_vclk, a_par, a_vs, a_cs, a_virq, a_lirq;
    logic b_hb, b_vb, b_vbh, b_dma, b_vclk, b_par, b_vs, b_cs, b_virq, b_lirq;
    int vectors = 0, miscompares = 0, k = 0, highs;

    always #5 clk = ~clk;

    video_timing_gen dut_a (
        .i_EMU_MCLK(clk), .i_MRST_n(rst_n), .i_EMU_CLK6MPCEN_n(ten_n), .i_HFLIP(hflip), .i_VFLIP(vflip),
        .i_LINE_CMP(cmp_a), .o_ABS_H(a_h), .o_ABS_V(a_v), .o_FLIP_H(a_fh), .o_FLIP_V(a_fv),
        .o_HBLANK_n(a_hb), .o_VBLANK_n(a_vb), .o_VBLANKH_n(a_vbh), .o_DMA_n(a_dma), .o_VCLK(a_vclk),
        .o_FRAMEPARITY(a_par), .o_VSYNC_n(a_vs), .o_CSYNC_n(a_cs), .o_VBL_IRQ(a_virq), .o_LINE_IRQ(a_lirq)
    );

    video_timing_gen #(
        .H_START(448), .H_END(511), .H_VINC(460), .VCLK_LEN(8), .V_START(480), .V_END(511),
        .VBL_START(504), .VBL_END(488), .VBLH_END(488), .DMA_START(500)
    ) dut_b (
        .i_EMU_MCLK(clk), .i_MRST_n(rst_n), .i_EMU_CLK6MPCEN_n(ten_n), .i_HFLIP(hflip), .i_VFLIP(vflip),
        .i_LINE_CMP(cmp_b), .o_ABS_H(b_h), .o_ABS_V(b_v), .o_FLIP_H(b_fh), .o_FLIP_V(b_fv),
        .o_HBLANK_n(b_hb), .o_VBLANK_n(b_vb), .o_VBLANKH_n(b_vbh), .o_DMA_n(b_dma), .o_VCLK(b_vclk),
        .o_FRAMEPARITY(b_par), .o_VSYNC_n(b_vs), .o_CSYNC_n(b_cs), .o_VBL_IRQ(b_virq), .o_LINE_IRQ(b_lirq)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
        k += n;
    endtask

    initial begin
        rst_n = 1'b0; ten_n = 1'b1; hflip = 1'b0; vflip = 1'b0; cmp_a = 9'd300; cmp_b = 9'd490;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_h", a_h, 128);
        chk("rst_v", a_v, 8'hF8);
        chk("rst_vbl", a_vb, 0);
        chk("rst_vblh", a_vbh, 0);
        chk("rst_dma", a_dma, 1);
        chk("rst_vclk", a_vclk, 0);
        chk("rst_par", a_par, 0);
        chk("rst_csync", a_cs, 0);
        chk("rst_hblank", a_hb, 0);
        chk("rst_irq", {a_virq, a_lirq}, 0);
        chk("rst_b_h", b_h, 448);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_h", a_h, 128);
        chk("idle_v", a_v, 8'hF8);
        ten_n = 1'b0;
        adv(13);
        chk("b_first_v", b_v, 8'hE1);
        chk("b_first_vblh", b_vbh, 0);
        adv(47 - k);
        chk("h_vinc", a_h, 175);
        chk("v_before", a_v, 8'hF8);
        chk("vclk_before", a_vclk, 0);
        adv(1);
        chk("h_after", a_h, 176);
        chk("v_249", a_v, 8'hF9);
        chk("vclk_rise", a_vclk, 1);
        chk("vbl_249", a_vb, 0);
        chk("vblh_249", a_vbh, 0);
        chk("dma_249", a_dma, 1);
        adv(79 - k);
        chk("vclk_last", a_vclk, 1);
        adv(1);
        chk("vclk_fall", a_vclk, 0);
        adv(432 - k);
        chk("v_250", a_v, 8'hFA);
        highs = 0;
        for (int i = 0; i < 384; i++) begin
            adv(1);
            highs += int'(a_vclk);
        end
        chk("vclk_len", highs, 32);
        for (int n = 1; n <= 2; n++) begin
            for (int l = 481; l <= 511; l++) begin
                adv(13 + (l - 481) * 64 + n * 2048 - k);
                chk($sformatf("b_v_%0d", l), b_v, l & 255);
                chk($sformatf("b_vbl_%0d", l), b_vb, int'(l >= 488 && l < 504));
                chk($sformatf("b_vblh_%0d", l), b_vbh, int'(!(l < 488)));
                chk($sformatf("b_dma_%0d", l), b_dma, int'(!(l >= 500 && l < 504)));
                chk($sformatf("b_par_%0d", l), b_par, (n + int'(l >= 504)) & 1);
                chk($sformatf("b_virq_%0d", l), b_virq, IRQ & int'(l == 504));
                chk($sformatf("b_lirq_%0d", l), b_lirq, IRQ & int'(l == 490));
            end
            adv(1997 + n * 2048 - k);
            chk("b_wrap_v", b_v, 8'hE0);
            chk("b_wrap_vs", b_vs, 1);
            chk("b_wrap_vbl", b_vb, 0);
            chk("b_wrap_vblh", b_vbh, 1);
            chk("b_wrap_dma", b_dma, 1);
            chk("b_wrap_par", b_par, (n + 1) & 1);
        end
        adv(8880 - k);
        chk("v_272", a_v, 8'h10);
        chk("vs_272", a_vs, 1);
        chk("vbl_272", a_vb, 1);
        chk("vblh_272", a_vbh, 1);
        chk("csync_vclk_hi", a_cs, 0);
        vflip = 1'b1;
        #1;
        chk("flip_v", a_fv, 8'hEF);
        vflip = 1'b0;
        #1;
        chk("noflip_v", a_fv, 8'h10);
        adv(9125 - k);
        chk("h_1a5", a_h, 9'h1A5);
        chk("csync_vclk_lo", a_cs, 1);
        chk("hblank_hi", a_hb, 1);
        hflip = 1'b1;
        #1;
        chk("flip_h", a_fh, 8'h5A);
        hflip = 1'b0;
        #1;
        chk("noflip_h", a_fh, 8'hA5);
        adv(9215 - k);
        chk("h_end", a_h, 511);
        adv(1);
        chk("h_reload", a_h, 128);
        chk("hblank_lo", a_hb, 0);
        ten_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("gate_h", a_h, 128);
        chk("gate_v", a_v, 8'h10);
        chk("gate_b_h", b_h, 448);
        ten_n = 1'b0;
        adv(19632 - k);
        chk("v_300", a_v, 8'h2C);
        chk("vclk_300", a_vclk, 1);
        chk("lirq_300", a_lirq, IRQ);
        adv(1);
        chk("lirq_drop", a_lirq, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_h", a_h, 128);
        chk("mid_rst_v", a_v, 8'hF8);
        chk("mid_rst_vbl", a_vb, 0);
        chk("mid_rst_dma", a_dma, 1);
        chk("mid_rst_vclk", a_vclk, 0);
        chk("mid_rst_par", a_par, 0);
        chk("mid_rst_csync", a_cs, 0);
        chk("mid_rst_b_v", b_v, 8'hE0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
